// File: rtl/minc_pkg.sv
// -----------------------------------------------------------------------------
// minc_pkg
// Shared types and sizes for the minc data-RAM arbiter slice.
//   arb_state_t : arbiter FSM states (idle / host holds the RAM)
//   owner_t     : which requester issued the read now in flight
//   MINC_AW/DW  : default RAM address / data widths
// -----------------------------------------------------------------------------
package minc_pkg;

  localparam int unsigned MINC_AW = 8;
  localparam int unsigned MINC_DW = 8;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_HOST_LOCK = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

endpackage

// File: rtl/minc_starve_ctr.sv
// -----------------------------------------------------------------------------
// minc_starve_ctr
// Saturating count of consecutive cycles the host was denied. Only built
// when MINC_ARB_STARVE_GUARD_EN is defined.
//   CLK, nRESET : clock, asynchronous active-low reset
//   inc_i       : host requested but was not granted this cycle
//   clr_i       : host granted or host request dropped (wins over inc_i)
//   hit_o       : count has reached MAX, host must win the next grant
// -----------------------------------------------------------------------------
module minc_starve_ctr #(
  parameter int unsigned MAX = 4
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_o
);

  localparam int unsigned CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign hit_o = (cnt_q == CW'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !hit_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/minc_ram_arbiter.sv
// -----------------------------------------------------------------------------
// minc_ram_arbiter
// Shares the single-port minc data RAM between the CPU core and the host
// debug/loader port. At most one access is granted per cycle, the CPU has
// fixed priority, and the host can lock the RAM for bursts. Synchronous read
// data is steered back to whichever side issued the read.
//
// Optional build macro: MINC_ARB_STARVE_GUARD_EN
//   Defined   : after STARVE_MAX consecutive denied host cycles the host
//               beats the CPU for one grant.
//   Undefined : strict CPU priority, no starvation counter.
//
// Ports
//   CLK, nRESET                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata       CPU request (held until cpu_gnt)
//   cpu_gnt/rvalid/rdata        CPU grant and read response
//   host_req/we/addr/wdata      host request (held until host_gnt)
//   host_lock                   keep the RAM owned by the host after its grant
//   host_gnt/rvalid/rdata       host grant and read response
//   mem_en/we/addr/wdata        RAM macro command
//   mem_rdata                   RAM read data, valid the cycle after a read
//   locked                      host currently owns the RAM
// -----------------------------------------------------------------------------
module minc_ram_arbiter
  import minc_pkg::*;
#(
  parameter int unsigned AW         = MINC_AW,
  parameter int unsigned DW         = MINC_DW,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_lock,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          locked
);

  arb_state_t state_q, state_d;
  owner_t     owner_q, owner_d;
  logic       force_host;

`ifdef MINC_ARB_STARVE_GUARD_EN
  logic starve_hit;

  minc_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve_ctr (
    .CLK    (CLK),
    .nRESET (nRESET),
    .inc_i  (host_req & ~host_gnt),
    .clr_i  (host_gnt | ~host_req),
    .hit_o  (starve_hit)
  );

  assign force_host = starve_hit & host_req;
`else
  assign force_host = 1'b0;
`endif

  // Grant / next-state decode.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req && !force_host) begin
          cpu_gnt = 1'b1;
        end else if (host_req) begin
          host_gnt = 1'b1;
          if (host_lock) begin
            state_d = ST_HOST_LOCK;
          end
        end
      end
      ST_HOST_LOCK: begin
        // CPU is stalled; the host keeps the RAM until it drops host_lock.
        host_gnt = host_req;
        if (!host_lock) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // No access may reach the RAM while reset is asserted.
    if (!nRESET) begin
      cpu_gnt  = 1'b0;
      host_gnt = 1'b0;
    end
  end

  // Record who owns the read whose data returns next cycle.
  always_comb begin
    owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_we) begin
      owner_d = OWN_CPU;
    end else if (host_gnt && !host_we) begin
      owner_d = OWN_HOST;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // RAM command muxed from the granted side; write enable only with a grant.
  assign mem_en    = cpu_gnt | host_gnt;
  assign mem_we    = cpu_gnt ? cpu_we    : (host_gnt & host_we);
  assign mem_addr  = cpu_gnt ? cpu_addr  : host_addr;
  assign mem_wdata = cpu_gnt ? cpu_wdata : host_wdata;

  assign cpu_rvalid  = (owner_q == OWN_CPU);
  assign host_rvalid = (owner_q == OWN_HOST);
  assign cpu_rdata   = mem_rdata;
  assign host_rdata  = mem_rdata;
  assign locked      = (state_q == ST_HOST_LOCK);

endmodule
